ed25519_stream_master: RTL and testbench
========================================

// Module: ed25519_stream_master
// PURPOSE
//  Host-side counterpart of the ed25519 core's 64-bit valid/ready stream ports.
//  Takes one parallel job (M, x, y), serialises it into 12 beats, collects 8 result beats, returns parallel (x, y).
//  Sits between the host/job scheduler and the ed25519 core; also used as the bench-side driver.
// PARAMETERS
//  WORD_W          64        stream data width (fixed; others derived from it)
//  IN_BEATS        12        job beats: M, x, y, 4 words each, MSB word first
//  OUT_BEATS       8         result beats: x then y, 4 words each, MSB word first
//  TIMEOUT_CYCLES  1000000   max consecutive RECV cycles without a result beat; 0 disables the watchdog
// PORTS
//  i_clk        in   1    clock
//  i_rst        in   1    reset: asynchronous, active-high
//  i_job_valid  in   1    job request
//  o_job_ready  out  1    job accepted when i_job_valid & o_job_ready
//  i_job_m      in   256  scalar M
//  i_job_x      in   256  point x
//  i_job_y      in   256  point y
//  o_in_valid   out  1    beat toward core
//  i_in_ready   in   1    core accepts beat
//  o_in_data    out  64   beat payload
//  i_out_valid  in   1    result beat from core
//  o_out_ready  out  1    master accepts result beat
//  i_out_data   in   64   result payload
//  o_res_valid  out  1    result available
//  i_res_ready  in   1    host takes result
//  o_res_x      out  256  result x
//  o_res_y      out  256  result y
//  o_res_timeout out 1    result aborted by watchdog; o_res_x/y = 0
//  o_busy       out  1    state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset (async) clears all outputs, counters and shift registers to 0; state -> IDLE.
//  - FSM: IDLE -> SEND -> RECV -> DONE -> IDLE.
//  - IDLE: o_job_ready=1.
//    On job handshake: tx_sr <= {M,x,y}, beat_cnt <= 0; next cycle o_in_valid=1, o_in_data=M[255:192] (1-cycle latency).
//  - SEND: o_in_data = tx_sr[767:704]; on i_in_ready & o_in_valid: shift tx_sr left 64, beat_cnt++.
//    o_in_valid/o_in_data held stable while not accepted; 1 beat/cycle when i_in_ready held high.
//    Beat 11 accepted -> o_in_valid=0, o_out_ready=1, beat_cnt<=0, wd_cnt<=0, RECV.
//  - RECV: o_out_ready=1. On i_out_valid & o_out_ready: rx_sr <= {rx_sr[447:0], i_out_data}, beat_cnt++, wd_cnt<=0.
//    8th beat -> o_out_ready=0, o_res_x=rx[511:256], o_res_y=rx[255:0], o_res_valid=1, DONE.
//    No beat: wd_cnt++.
//    If TIMEOUT_CYCLES!=0 and wd_cnt reaches TIMEOUT_CYCLES-1 with no beat:
//      DONE with o_res_timeout=1, o_res_x/y=0, partial beats discarded.
//    A beat on the same cycle as expiry wins (no timeout).
//  - Result beats are never accepted outside RECV (o_out_ready=0).
//  - DONE: o_res_valid and data held until i_res_ready. On handshake: o_res_valid=0, o_res_timeout=0, IDLE.
//    o_job_ready stays 0 in DONE: next job is accepted no earlier than 1 cycle after the result handshake.
//  - beat_cnt 4 bits, wraps only via explicit clear; wd_cnt width $clog2(TIMEOUT_CYCLES+1), saturating.
//  - Reset mid-transfer abandons the job; the core must be reset in the same cycle (shared i_rst).
// STRUCTURE
//  - ed25519_pkg: WORD_W, IN_BEATS, OUT_BEATS, stream_state_t {S_IDLE,S_SEND,S_RECV,S_DONE}.
//  - Sub-module ed25519_word_shifter #(WORD_W, DEPTH): load/shift-out/shift-in register.
//    Instanced twice: TX depth 12, RX depth 8.
//  - FSM, beat counter and watchdog stay in this module.
// TESTING
//  - Job M=0x1, x=0x2, y=0x3, i_in_ready=1, core model returns x=0xA, y=0xB:
//      12 consecutive beats, beat0=0, beat3=0x1, beat11=0x3;
//      o_res_x=0xA, o_res_y=0xB, timeout=0.
//  - i_in_ready pattern 1,0,1,0...: exactly 12 handshakes, o_in_data unchanged across every stalled cycle,
//      no beat lost or duplicated.
//  - Result beats with 3-cycle gaps, then i_res_ready low 5 cycles:
//      o_res_valid and data held 5 cycles, o_job_ready=0 throughout.
//  - TIMEOUT_CYCLES=16, core never sends results:
//      o_res_valid=1, o_res_timeout=1, res=0, exactly 16 cycles after RECV entry.
//    Repeat with a beat arriving on cycle 16: no timeout, wd_cnt restarts.
//  - Assert i_rst asynchronously mid-SEND after beat 5: o_in_valid=0 and o_busy=0 before the next clock edge;
//      next job starts again at beat 0 = M[255:192].
//  - i_job_valid held high with 2 jobs: second job accepted exactly 1 cycle after first result handshake;
//      both results correct.

Source files
------------

// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared stream geometry and FSM state encoding for the ed25519 stream master.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

package ed25519_pkg;

  localparam int WORD_W    = 64;
  localparam int IN_BEATS  = 12;
  localparam int OUT_BEATS = 8;
  localparam int COORD_W   = 4 * WORD_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } stream_state_t;

endpackage

`default_nettype wire

// File: rtl/ed25519_word_shifter.sv
// ed25519_word_shifter: word-granular register with parallel load and MSB-first shift.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module ed25519_word_shifter #(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_load,
  input  logic                     i_shift,
  input  logic [WORD_W*DEPTH-1:0]  i_load_data,
  input  logic [WORD_W-1:0]        i_word,
  output logic [WORD_W*DEPTH-1:0]  o_data
);

  logic [WORD_W*DEPTH-1:0] data_q;

  // Shift moves the register one word toward the MSB end and appends i_word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
    end else if (i_clear) begin
      data_q <= '0;
    end else if (i_load) begin
      data_q <= i_load_data;
    end else if (i_shift) begin
      data_q <= {data_q[WORD_W*(DEPTH-1)-1:0], i_word};
    end
  end

  assign o_data = data_q;

endmodule

`default_nettype wire

// File: rtl/ed25519_stream_master.sv
// ed25519_stream_master: serialises one (M, x, y) job into 12 stream beats and collects 8 result beats.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module ed25519_stream_master
  import ed25519_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_job_valid,
  output logic                o_job_ready,
  input  logic [COORD_W-1:0]  i_job_m,
  input  logic [COORD_W-1:0]  i_job_x,
  input  logic [COORD_W-1:0]  i_job_y,
  output logic                o_in_valid,
  input  logic                i_in_ready,
  output logic [WORD_W-1:0]   o_in_data,
  input  logic                i_out_valid,
  output logic                o_out_ready,
  input  logic [WORD_W-1:0]   i_out_data,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [COORD_W-1:0]  o_res_x,
  output logic [COORD_W-1:0]  o_res_y,
  output logic                o_res_timeout,
  output logic                o_busy
);

  localparam int TX_W = WORD_W * IN_BEATS;
  localparam int RX_W = WORD_W * OUT_BEATS;
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};
  localparam logic [3:0] LAST_IN  = 4'(IN_BEATS - 1);
  localparam logic [3:0] LAST_OUT = 4'(OUT_BEATS - 1);

  stream_state_t        state_q;
  logic [3:0]           beat_cnt_q;
  logic [WD_W-1:0]      wd_cnt_q;
  logic                 job_ready_q;
  logic                 in_valid_q;
  logic                 out_ready_q;
  logic                 res_valid_q;
  logic                 res_timeout_q;
  logic                 busy_q;
  logic [COORD_W-1:0]   res_x_q;
  logic [COORD_W-1:0]   res_y_q;

  logic                 tx_load_w;
  logic                 tx_shift_w;
  logic                 rx_shift_w;
  logic                 rx_clear_w;
  logic                 wd_expire_w;
  logic [TX_W-1:0]      tx_data_w;
  logic [RX_W-1:0]      rx_data_w;
  logic [RX_W-1:0]      rx_next_w;
  logic                 unused_w;

  assign tx_load_w   = (state_q == S_IDLE) && job_ready_q && i_job_valid;
  assign tx_shift_w  = (state_q == S_SEND) && in_valid_q && i_in_ready;
  assign rx_shift_w  = (state_q == S_RECV) && out_ready_q && i_out_valid;
  // A beat landing on the expiry cycle takes priority over the watchdog.
  assign wd_expire_w = (TIMEOUT_CYCLES != 0) && (state_q == S_RECV) && !rx_shift_w
                       && (wd_cnt_q == WD_LIMIT);
  assign rx_clear_w  = tx_load_w || wd_expire_w;
  assign rx_next_w   = {rx_data_w[RX_W-WORD_W-1:0], i_out_data};

  ed25519_word_shifter #(
    .WORD_W (WORD_W),
    .DEPTH  (IN_BEATS)
  ) u_tx_shifter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (1'b0),
    .i_load      (tx_load_w),
    .i_shift     (tx_shift_w),
    .i_load_data ({i_job_m, i_job_x, i_job_y}),
    .i_word      ({WORD_W{1'b0}}),
    .o_data      (tx_data_w)
  );

  ed25519_word_shifter #(
    .WORD_W (WORD_W),
    .DEPTH  (OUT_BEATS)
  ) u_rx_shifter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (rx_clear_w),
    .i_load      (1'b0),
    .i_shift     (rx_shift_w),
    .i_load_data ({RX_W{1'b0}}),
    .i_word      (i_out_data),
    .o_data      (rx_data_w)
  );

  assign unused_w = ^{tx_data_w[TX_W-WORD_W-1:0], rx_data_w[RX_W-1:RX_W-WORD_W]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      beat_cnt_q    <= '0;
      wd_cnt_q      <= '0;
      job_ready_q   <= 1'b0;
      in_valid_q    <= 1'b0;
      out_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      res_x_q       <= '0;
      res_y_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          job_ready_q <= 1'b1;
          if (tx_load_w) begin
            job_ready_q <= 1'b0;
            in_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
            beat_cnt_q  <= '0;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_shift_w) begin
            if (beat_cnt_q == LAST_IN) begin
              in_valid_q  <= 1'b0;
              out_ready_q <= 1'b1;
              beat_cnt_q  <= '0;
              wd_cnt_q    <= '0;
              state_q     <= S_RECV;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
          end
        end
        S_RECV: begin
          if (rx_shift_w) begin
            wd_cnt_q <= '0;
            if (beat_cnt_q == LAST_OUT) begin
              out_ready_q <= 1'b0;
              res_x_q     <= rx_next_w[RX_W-1:COORD_W];
              res_y_q     <= rx_next_w[COORD_W-1:0];
              res_valid_q <= 1'b1;
              beat_cnt_q  <= '0;
              state_q     <= S_DONE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
          end else if (wd_expire_w) begin
            out_ready_q   <= 1'b0;
            res_x_q       <= '0;
            res_y_q       <= '0;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            beat_cnt_q    <= '0;
            state_q       <= S_DONE;
          end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
        end
        S_DONE: begin
          // Ready is raised on the handshake edge so a waiting job lands one cycle later.
          if (i_res_ready) begin
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            job_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_job_ready   = job_ready_q;
  assign o_in_valid    = in_valid_q;
  assign o_in_data     = tx_data_w[TX_W-1:TX_W-WORD_W];
  assign o_out_ready   = out_ready_q;
  assign o_res_valid   = res_valid_q;
  assign o_res_x       = res_x_q;
  assign o_res_y       = res_y_q;
  assign o_res_timeout = res_timeout_q;
  assign o_busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ed25519_stream_master.sv
// tb_ed25519_stream_master: table-driven and randomized checks of the ed25519 stream master.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ed25519_stream_master;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_job_valid;
  logic         o_job_ready;
  logic [255:0] i_job_m, i_job_x, i_job_y;
  logic         o_in_valid;
  logic         i_in_ready;
  logic [63:0]  o_in_data;
  logic         i_out_valid;
  logic         o_out_ready;
  logic [63:0]  i_out_data;
  logic         o_res_valid;
  logic         i_res_ready;
  logic [255:0] o_res_x, o_res_y;
  logic         o_res_timeout;
  logic         o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  ed25519_stream_master #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_m(i_job_m), .i_job_x(i_job_x), .i_job_y(i_job_y),
    .o_in_valid(o_in_valid), .i_in_ready(i_in_ready), .o_in_data(o_in_data),
    .i_out_valid(i_out_valid), .o_out_ready(o_out_ready), .i_out_data(i_out_data),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_x(o_res_x), .o_res_y(o_res_y),
    .o_res_timeout(o_res_timeout), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [255:0] m, x, y;
    logic [255:0] rx, ry;
    int           mode;
    int           gap;
    int           delay;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: job words are M, x, y concatenated, sent most significant word first.
  function automatic logic [63:0] job_word(input logic [255:0] m, x, y, input int idx);
    logic [767:0] cat;
    cat = {m, x, y};
    return cat[767 - 64*idx -: 64];
  endfunction

  function automatic logic [63:0] res_word(input logic [255:0] rx, ry, input int idx);
    logic [511:0] cat;
    cat = {rx, ry};
    return cat[511 - 64*idx -: 64];
  endfunction

  task automatic do_accept(input logic [255:0] m, x, y);
    int w = 0;
    while (!o_job_ready && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    check("job_ready_wait", o_job_ready, 1);
    i_job_valid = 1'b1;
    i_job_m = m; i_job_x = x; i_job_y = y;
    @(negedge i_clk);
    i_job_valid = 1'b0;
    check("first_beat", {o_in_valid, o_in_data, o_busy, o_job_ready, o_out_ready},
          {1'b1, m[255:192], 1'b1, 1'b0, 1'b0});
  endtask

  // mode 0: ready always, 1: alternating 1,0,..., 2: random
  task automatic do_send(input logic [255:0] m, x, y, input int mode, input int stop_at);
    int n = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [63:0] held = '0;
    bit rdy;
    while (n < stop_at && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (stalled) check("stall_hold", {o_in_valid, o_in_data}, {1'b1, held});
      i_in_ready = rdy;
      if (o_in_valid && rdy) begin
        check($sformatf("beat%0d", n), o_in_data, job_word(m, x, y, n));
        n++;
        stalled = 0;
      end else if (o_in_valid) begin
        stalled = 1;
        held = o_in_data;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_in_ready = 1'b0;
    check("beats_sent", n, stop_at);
    if (stop_at == 12) begin
      check("send_end", {o_in_valid, o_out_ready}, 2'b01);
      if (mode == 0) check("send_cycles", cyc, 12);
    end
  endtask

  task automatic do_recv(input logic [255:0] rx, ry, input int gap);
    int k = 0;
    int idle = 0;
    int cyc = 0;
    while (k < 8 && cyc < 400) begin
      i_out_valid = (idle >= gap);
      i_out_data  = i_out_valid ? res_word(rx, ry, k) : 64'hDEAD_BEEF_0000_0000;
      if (i_out_valid && o_out_ready) begin
        k++;
        idle = 0;
      end else begin
        idle++;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_out_valid = 1'b0;
    check("beats_recv", k, 8);
  endtask

  task automatic do_result(input logic [255:0] ex, ey, input bit eto, input int delay);
    check("res", {o_res_valid, o_res_timeout, o_out_ready, o_res_x, o_res_y},
          {1'b1, eto, 1'b0, ex, ey});
    for (int i = 0; i < delay; i++) begin
      i_res_ready = 1'b0;
      @(negedge i_clk);
      check("res_hold", {o_res_valid, o_job_ready, o_res_timeout, o_res_x, o_res_y},
            {1'b1, 1'b0, eto, ex, ey});
    end
    i_res_ready = 1'b1;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    check("res_done", {o_res_valid, o_res_timeout, o_job_ready, o_busy}, 4'b0010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    logic [255:0] m, x, y, rx, ry;
    vec_t a, b;

    vecs[0] = '{m: 256'h1, x: 256'h2, y: 256'h3, rx: 256'hA, ry: 256'hB, mode: 0, gap: 0, delay: 0};
    vecs[1] = '{m: rand256(), x: rand256(), y: rand256(), rx: rand256(), ry: rand256(),
                mode: 1, gap: 0, delay: 1};
    vecs[2] = '{m: rand256(), x: rand256(), y: rand256(), rx: rand256(), ry: rand256(),
                mode: 0, gap: 3, delay: 5};
    vecs[3] = '{m: rand256(), x: rand256(), y: rand256(), rx: rand256(), ry: rand256(),
                mode: 2, gap: int'($urandom_range(0, 4)), delay: int'($urandom_range(0, 3))};
    vecs[4] = '{m: rand256(), x: rand256(), y: rand256(), rx: rand256(), ry: rand256(),
                mode: 2, gap: 1, delay: 2};

    i_rst = 1'b1; i_job_valid = 0; i_job_m = '0; i_job_x = '0; i_job_y = '0;
    i_in_ready = 0; i_out_valid = 0; i_out_data = '0; i_res_ready = 0;
    repeat (3) @(negedge i_clk);
    check("reset_outputs", {o_job_ready, o_in_valid, o_in_data, o_out_ready, o_res_valid,
                            o_res_x, o_res_y, o_res_timeout, o_busy}, '0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_ready", {o_job_ready, o_busy}, 2'b10);

    foreach (vecs[i]) begin
      do_accept(vecs[i].m, vecs[i].x, vecs[i].y);
      do_send(vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].mode, 12);
      do_recv(vecs[i].rx, vecs[i].ry, vecs[i].gap);
      do_result(vecs[i].rx, vecs[i].ry, 1'b0, vecs[i].delay);
    end

    // Watchdog expiry with no result beats at all.
    m = rand256(); x = rand256(); y = rand256();
    do_accept(m, x, y);
    do_send(m, x, y, 0, 12);
    cnt = 0;
    while (o_out_ready && cnt < 100) begin
      @(negedge i_clk);
      cnt++;
    end
    check("wd_cycles", cnt, 16);
    do_result('0, '0, 1'b1, 2);

    // A beat on the expiry cycle wins and restarts the watchdog; the partial beat is discarded.
    do_accept(m, x, y);
    do_send(m, x, y, 0, 12);
    cnt = 0;
    while (o_out_ready && cnt < 100) begin
      i_out_valid = (cnt == 15);
      i_out_data  = 64'h5555_AAAA_1234_5678;
      @(negedge i_clk);
      cnt++;
    end
    i_out_valid = 1'b0;
    check("wd_restart_cycles", cnt, 32);
    do_result('0, '0, 1'b1, 0);

    // Asynchronous reset after six beats abandons the job immediately.
    m = rand256(); x = rand256(); y = rand256();
    do_accept(m, x, y);
    do_send(m, x, y, 0, 6);
    #2 i_rst = 1'b1;
    #1 check("rst_async", {o_in_valid, o_busy, o_job_ready, o_out_ready}, 4'b0000);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    rx = rand256(); ry = rand256();
    do_accept(m, x, y);
    do_send(m, x, y, 0, 12);
    do_recv(rx, ry, 0);
    do_result(rx, ry, 1'b0, 0);

    // Back-to-back jobs with i_job_valid held high.
    a = '{m: rand256(), x: rand256(), y: rand256(), rx: rand256(), ry: rand256(), mode: 0, gap: 0, delay: 0};
    b = '{m: rand256(), x: rand256(), y: rand256(), rx: rand256(), ry: rand256(), mode: 0, gap: 0, delay: 0};
    cnt = 0;
    while (!o_job_ready && cnt < 50) begin
      @(negedge i_clk);
      cnt++;
    end
    i_job_valid = 1'b1;
    i_job_m = a.m; i_job_x = a.x; i_job_y = a.y;
    @(negedge i_clk);
    check("b2b_first", {o_in_valid, o_in_data}, {1'b1, a.m[255:192]});
    i_job_m = b.m; i_job_x = b.x; i_job_y = b.y;
    do_send(a.m, a.x, a.y, 0, 12);
    do_recv(a.rx, a.ry, 0);
    do_result(a.rx, a.ry, 1'b0, 0);
    @(negedge i_clk);
    check("b2b_second", {o_in_valid, o_in_data, o_job_ready, o_busy}, {1'b1, b.m[255:192], 1'b0, 1'b1});
    i_job_valid = 1'b0;
    do_send(b.m, b.x, b.y, 2, 12);
    do_recv(b.rx, b.ry, 2);
    do_result(b.rx, b.ry, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
